// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM encoding,
// default start-acknowledge timeout and the grant index width helper.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_LOCKED    = 3'd4
    } sched_state_t;

    localparam int ACK_TIMEOUT_DEF = 15;

    // Width of a requester index; never below one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: the first set bit of req at or above ptr,
// wrapping around, wins.
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [grant_w(NUM_REQ)-1:0] ptr,
    output logic [grant_w(NUM_REQ)-1:0] winner,
    output logic                        any_valid
);

    localparam int GW = grant_w(NUM_REQ);

    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = |req;
        // Walk from the farthest offset inward so the nearest candidate is written last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[GW-1:0]]) begin
                winner = idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers,
// with per-message locking via req_last and a start-acknowledge timeout.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    output logic [grant_w(NUM_REQ)-1:0]   grant_id,
    output logic                          grant_active,
    output logic                          tx_err
);

    localparam int GW    = grant_w(NUM_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_t          state_reg, state_next;
    logic [GW-1:0]         grant_reg, rr_ptr_reg, pick_id;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic                  last_reg, tx_start_reg, tx_err_reg, active_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  take_grant, load_byte, byte_done, ack_expired;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = (state_reg == ST_SEND) && (grant_reg == GW'(gi));
        end
    endgenerate

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .winner    (pick_id),
        .any_valid (pick_any)
    );

    always_comb begin
        state_next  = state_reg;
        take_grant  = 1'b0;
        load_byte   = 1'b0;
        byte_done   = 1'b0;
        ack_expired = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any && !tx_busy) begin
                    take_grant = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                load_byte  = 1'b1;
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // No acknowledge: flag it and treat the byte as sent.
                    ack_expired = 1'b1;
                    byte_done   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (req_valid[grant_reg]) begin
                    state_next = ST_SEND;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (byte_done) begin
            state_next = last_reg ? ST_IDLE : ST_LOCKED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= '0;
            tx_data_reg  <= '0;
            last_reg     <= 1'b0;
            tx_start_reg <= 1'b0;
            tx_err_reg   <= 1'b0;
            active_reg   <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= load_byte;
            tx_err_reg   <= ack_expired;
            if (take_grant) begin
                grant_reg  <= pick_id;
                active_reg <= 1'b1;
            end
            if (load_byte) begin
                tx_data_reg <= slice[grant_reg];
                last_reg    <= req_last[grant_reg];
                cnt_reg     <= '0;
            end else if (state_reg == ST_WAIT_ACK && !tx_busy) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // Message finished: hand priority to the next requester up.
            if (byte_done && last_reg) begin
                active_reg <= 1'b0;
                rr_ptr_reg <= (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + GW'(1);
            end
        end
    end

    assign tx_data      = tx_data_reg;
    assign tx_start     = tx_start_reg;
    assign tx_err       = tx_err_reg;
    assign grant_id     = grant_reg;
    assign grant_active = active_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: table of round-robin vectors plus
// directed sequences for latency, locking, busy entry, timeout and reset.
module tb_uart_tx_sched;

    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int BIT_CYC  = (42_000_000 + 57_600) / 115_200;
    localparam int BYTE_CYC = 10 * BIT_CYC;
    localparam int IDLE_MAX = 40000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            grant_active;
    logic            tx_err;

    uart_tx_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ACK_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .tx_err       (tx_err)
    );

    initial clk = 1'b0;
    always #12 clk = ~clk;

    // Behavioural uart_tx: busy from the cycle after start for ten bit times.
    logic model_en;
    logic force_busy;
    logic model_busy;
    int   model_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (model_busy) begin
            if (model_cnt == BYTE_CYC - 1) model_busy <= 1'b0;
            model_cnt <= model_cnt + 1;
        end else if (tx_start && model_en) begin
            model_busy <= 1'b1;
            model_cnt  <= 0;
        end
    end
    assign tx_busy = model_busy | force_busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] msg_d [N][8];
    logic       msg_l [N][8];
    int         msg_len [N];
    int         msg_pos [N];
    int         ready_cnt [N];
    logic [1:0] log_id [16];
    logic [7:0] log_d [16];
    int         n_log;
    int         multi_cnt;
    int         err_seen;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          n;
        logic [15:0] order;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_msgs();
        for (int r = 0; r < N; r++) begin
            msg_len[r]   = 0;
            msg_pos[r]   = 0;
            ready_cnt[r] = 0;
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        msg_d[r][msg_len[r]] = d;
        msg_l[r][msg_len[r]] = l;
        msg_len[r]++;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (msg_pos[r] < msg_len[r]) begin
                req_valid[r]         = 1'b1;
                req_data[r*DW +: DW] = msg_d[r][msg_pos[r]];
                req_last[r]          = msg_l[r][msg_pos[r]];
            end else begin
                req_valid[r]         = 1'b0;
                req_data[r*DW +: DW] = 8'h00;
                req_last[r]          = 1'b0;
            end
        end
    endtask

    function automatic logic pending();
        for (int r = 0; r < N; r++) begin
            if (msg_pos[r] < msg_len[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        logic [N-1:0] rdy;
        rdy = req_ready;
        if ($countones(rdy) > 1) multi_cnt++;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (rdy[r]) begin
                ready_cnt[r]++;
                if (msg_pos[r] < msg_len[r]) msg_pos[r]++;
            end
        end
        if (tx_start) begin
            $display("tx_start id=%0d data=0x%02h t=%0t", grant_id, tx_data, $time);
            if (n_log < 16) begin
                log_id[n_log] = grant_id;
                log_d[n_log]  = tx_data;
            end
            n_log++;
        end
        if (tx_err) err_seen++;
        drive();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pending() || tx_busy || grant_active) && n < IDLE_MAX) begin
            step();
            n++;
        end
        check({name, "_idle_reached"}, 32'(n < IDLE_MAX), 32'd1);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!tx_start && n < 12) begin
            step();
            n++;
        end
        check({name, "_tx_start_seen"}, 32'(tx_start), 32'd1);
    endtask

    task automatic check_log(input string name, input int k, input logic [1:0] id, input logic [7:0] d);
        check($sformatf("%s_id%0d", name, k), 32'(log_id[k]), 32'(id));
        check($sformatf("%s_data%0d", name, k), 32'(log_d[k]), 32'(d));
    endtask

    initial begin
        int k;
        logic [3:0] id;

        rst        = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        model_en   = 1'b1;
        force_busy = 1'b0;
        n_log      = 0;
        multi_cnt  = 0;
        err_seen   = 0;
        for (int i = 0; i < 16; i++) begin
            log_id[i] = '0;
            log_d[i]  = '0;
        end
        clear_msgs();

        vecs[0] = '{4'b1111, 32'h13121110, 4, 16'h3210};
        vecs[1] = '{4'b0101, 32'h00C300A1, 2, 16'h0020};
        vecs[2] = '{4'b1000, 32'h5E000000, 1, 16'h0003};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_grant_active", 32'(grant_active), 32'h0);
        check("rst_tx_err", 32'(tx_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin vectors: one byte (last=1) per valid requester.
        for (int v = 0; v < 3; v++) begin
            clear_msgs();
            n_log = 0;
            for (int r = 0; r < N; r++) begin
                if (vecs[v].valid[r]) load(r, vecs[v].data[r*8 +: 8], 1'b1);
            end
            drive();
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_count", v), 32'(n_log), 32'(vecs[v].n));
            for (int j = 0; j < vecs[v].n; j++) begin
                id = vecs[v].order[j*4 +: 4];
                check_log($sformatf("vec%0d", v), j, id[1:0], vecs[v].data[id*8 +: 8]);
            end
            for (int r = 0; r < N; r++) begin
                check($sformatf("vec%0d_ready_cnt%0d", v, r), 32'(ready_cnt[r]), 32'(vecs[v].valid[r]));
            end
            check($sformatf("vec%0d_active_low", v), 32'(grant_active), 32'h0);
        end

        // Single byte latency: ready at cycle 1, tx_start at cycle 2.
        clear_msgs();
        n_log = 0;
        load(1, 8'h41, 1'b1);
        drive();
        check("single_ready_c0", 32'(req_ready), 32'h0);
        step();
        check("single_ready_c1", 32'(req_ready), 32'b0010);
        check("single_start_c1", 32'(tx_start), 32'h0);
        step();
        check("single_start_c2", 32'(tx_start), 32'h1);
        check("single_data_c2", 32'(tx_data), 32'h41);
        check("single_grant_id", 32'(grant_id), 32'h1);
        check("single_active", 32'(grant_active), 32'h1);
        check("single_ready_c2", 32'(req_ready), 32'h0);
        wait_idle("single");
        check("single_active_end", 32'(grant_active), 32'h0);
        check("single_data_hold", 32'(tx_data), 32'h41);
        check("single_grant_hold", 32'(grant_id), 32'h1);

        // Locked message from requester 2 while requester 0 waits.
        clear_msgs();
        n_log = 0;
        load(2, 8'h48, 1'b0);
        load(2, 8'h49, 1'b0);
        load(2, 8'h0A, 1'b1);
        load(0, 8'h55, 1'b1);
        drive();
        wait_idle("locked");
        check("locked_count", 32'(n_log), 32'd4);
        check_log("locked", 0, 2'd2, 8'h48);
        check_log("locked", 1, 2'd2, 8'h49);
        check_log("locked", 2, 2'd2, 8'h0A);
        check_log("locked", 3, 2'd0, 8'h55);

        // Busy at entry: no grant until tx_busy falls.
        clear_msgs();
        n_log = 0;
        force_busy = 1'b1;
        load(0, 8'h5A, 1'b1);
        drive();
        repeat (20) step();
        check("busy_no_ready", 32'(ready_cnt[0]), 32'h0);
        check("busy_no_active", 32'(grant_active), 32'h0);
        force_busy = 1'b0;
        step();
        check("busy_ready_c1", 32'(req_ready), 32'b0001);
        step();
        check("busy_start_c2", 32'(tx_start), 32'h1);
        check("busy_data_c2", 32'(tx_data), 32'h5A);
        wait_idle("busy");

        // Timeout on a last byte: back to IDLE.
        clear_msgs();
        n_log = 0;
        model_en = 1'b0;
        load(1, 8'h77, 1'b1);
        drive();
        wait_start("to1");
        k = 0;
        while (!tx_err && k < 40) begin
            step();
            k++;
        end
        check("to1_err_delay", 32'(k), 32'd15);
        check("to1_active_low", 32'(grant_active), 32'h0);
        step();
        check("to1_err_pulse", 32'(tx_err), 32'h0);
        model_en = 1'b1;
        wait_idle("to1");

        // Timeout mid-message: stays locked, other requester ignored.
        clear_msgs();
        n_log = 0;
        model_en = 1'b0;
        load(3, 8'h33, 1'b0);
        load(3, 8'h34, 1'b1);
        drive();
        wait_start("to0");
        k = 0;
        while (!tx_err && k < 40) begin
            step();
            k++;
        end
        model_en = 1'b1;
        check("to0_err_delay", 32'(k), 32'd15);
        check("to0_active_high", 32'(grant_active), 32'h1);
        check("to0_grant_id", 32'(grant_id), 32'h3);
        load(2, 8'h22, 1'b1);
        drive();
        wait_idle("to0");
        check("to0_count", 32'(n_log), 32'd3);
        check_log("to0", 0, 2'd3, 8'h33);
        check_log("to0", 1, 2'd3, 8'h34);
        check_log("to0", 2, 2'd2, 8'h22);

        // Reset during WAIT_DONE, then arbitration restarts from pointer 0.
        clear_msgs();
        n_log = 0;
        load(1, 8'h99, 1'b1);
        drive();
        wait_start("rstmid");
        repeat (5) step();
        check("rstmid_busy_before", 32'(tx_busy), 32'h1);
        #3;
        rst = 1'b0;
        #1;
        check("rstmid_tx_start", 32'(tx_start), 32'h0);
        check("rstmid_tx_data", 32'(tx_data), 32'h0);
        check("rstmid_active", 32'(grant_active), 32'h0);
        check("rstmid_grant_id", 32'(grant_id), 32'h0);
        check("rstmid_ready", 32'(req_ready), 32'h0);
        clear_msgs();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_log = 0;
        load(0, 8'hA0, 1'b1);
        load(3, 8'hA3, 1'b1);
        drive();
        wait_start("rstpost");
        check("rstpost_grant_id", 32'(grant_id), 32'h0);
        check("rstpost_data", 32'(tx_data), 32'hA0);

        check("ready_one_hot", 32'(multi_cnt), 32'h0);
        check("tx_err_total", 32'(err_seen), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
